// File: rtl/mxint_block_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mxint_block_exp_ctrl
// Purpose  : Collects NUM_BEATS beats of IN_SIZE two's-complement lanes,
//            derives one shared exponent for the whole block from the OR of
//            all lane magnitudes, then replays the stored beats unchanged,
//            each tagged with that exponent and a last-beat flag.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            data_in*          - input beat stream (valid/ready handshake)
//            data_out*         - replayed beats + shared exponent + last flag
// Revision : 1.0 - initial release
// ============================================================================
module mxint_block_exp_ctrl #(
    parameter int IN_SIZE   = 4,
    parameter int IN_WIDTH  = 16,
    parameter int NUM_BEATS = 4,
    parameter int EXP_WIDTH = $clog2(IN_WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  data_in [IN_SIZE],
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [IN_WIDTH-1:0]  data_out [IN_SIZE],
    output logic [EXP_WIDTH-1:0] data_out_exp,
    output logic                 data_out_last,
    output logic                 data_out_valid,
    input  logic                 data_out_ready
);

    localparam int                c_CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(NUM_BEATS - 1);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_EMIT    = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_CNT_W-1:0]    r_wr_cnt;
    logic [c_CNT_W-1:0]    r_rd_cnt;
    logic [IN_WIDTH-1:0]   r_or_acc;
    logic [EXP_WIDTH-1:0]  r_exp;
    logic [IN_WIDTH-1:0]   r_buf [NUM_BEATS][IN_SIZE];

    logic                  w_in_ready;
    logic                  w_out_valid;
    logic                  w_accept;
    logic                  w_out_hs;
    logic                  w_wr_last;
    logic                  w_rd_last;
    logic [IN_WIDTH-1:0]   w_or_next;
    logic [EXP_WIDTH-1:0]  w_exp_next;

    // Magnitude truncated to IN_WIDTH; the most negative value maps onto the
    // MSB alone, which reads correctly as an unsigned magnitude.
    function automatic logic [IN_WIDTH-1:0] abs_val(input logic [IN_WIDTH-1:0] x);
        return x[IN_WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    assign w_wr_last = (r_wr_cnt == c_LAST);
    assign w_rd_last = (r_rd_cnt == c_LAST);
    assign w_accept  = data_in_valid & w_in_ready;
    assign w_out_hs  = w_out_valid & data_out_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Both handshake qualifiers are forced low while rst is held so nothing
    // is accepted or presented during reset.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                w_in_ready = ~rst;
                if (data_in_valid && !rst && w_wr_last) begin
                    w_state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                w_out_valid = ~rst;
                if (data_out_ready && !rst && w_rd_last) begin
                    w_state_next = ST_COLLECT;
                end
            end
            default: w_state_next = ST_COLLECT;
        endcase
    end

    // ------------------------------------------------------------------
    // Magnitude accumulation and exponent extraction
    // ------------------------------------------------------------------
    // The accumulator includes the beat being accepted so the exponent
    // latched on the final beat covers the whole block.
    always_comb begin
        w_or_next = r_or_acc;
        for (int i = 0; i < IN_SIZE; i++) begin
            w_or_next = w_or_next | abs_val(data_in[i]);
        end
    end

    // Highest set bit position plus one; zero when no bit is set.
    always_comb begin
        w_exp_next = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (w_or_next[i]) begin
                w_exp_next = EXP_WIDTH'(i + 1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Counters, accumulator, exponent
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_or_acc <= '0;
            r_exp    <= '0;
        end else begin
            if (w_accept) begin
                r_or_acc <= w_or_next;
                if (w_wr_last) begin
                    r_wr_cnt <= '0;
                    r_exp    <= w_exp_next;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end
            if (w_out_hs) begin
                if (w_rd_last) begin
                    r_rd_cnt <= '0;
                    r_or_acc <= '0;
                end else begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
            end
        end
    end

    // Beat storage holds no control state, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < IN_SIZE; i++) begin
                r_buf[r_wr_cnt][i] <= data_in[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < IN_SIZE; i++) begin
            data_out[i] = r_buf[r_rd_cnt][i];
        end
    end

    assign data_in_ready  = w_in_ready;
    assign data_out_valid = w_out_valid;
    assign data_out_exp   = r_exp;
    assign data_out_last  = w_rd_last;

endmodule
`default_nettype wire

// File: tb/tb_mxint_block_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mxint_block_exp_ctrl
// Purpose  : Self-checking bench for mxint_block_exp_ctrl (default params).
//            Expected output beats are queued when a block finishes sending
//            and popped when the DUT presents a handshaken output beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mxint_block_exp_ctrl;

    localparam int IN_SIZE   = 4;
    localparam int IN_WIDTH  = 16;
    localparam int NUM_BEATS = 4;
    localparam int EXP_WIDTH = 5;

    typedef logic [IN_SIZE-1:0][IN_WIDTH-1:0] beat_t;
    typedef beat_t blk_t [NUM_BEATS];
    typedef struct packed {
        beat_t                data;
        logic [EXP_WIDTH-1:0] exp;
        logic                 last;
    } item_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    beat_t                din_p = '0;
    beat_t                dout_p;
    logic [IN_WIDTH-1:0]  data_in  [IN_SIZE];
    logic [IN_WIDTH-1:0]  data_out [IN_SIZE];
    logic                 data_in_valid = 1'b0;
    logic                 data_in_ready;
    logic [EXP_WIDTH-1:0] data_out_exp;
    logic                 data_out_last;
    logic                 data_out_valid;
    logic                 data_out_ready = 1'b1;

    int    n_cmp = 0;
    int    n_err = 0;
    item_t sb [$];
    item_t it;
    bit    bp_mode = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < IN_SIZE; i++) begin
            data_in[i] = din_p[i];
            dout_p[i]  = data_out[i];
        end
    end

    mxint_block_exp_ctrl #(
        .IN_SIZE   (IN_SIZE),
        .IN_WIDTH  (IN_WIDTH),
        .NUM_BEATS (NUM_BEATS),
        .EXP_WIDTH (EXP_WIDTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_exp   (data_out_exp),
        .data_out_last  (data_out_last),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference exponent: bit length of the OR of integer magnitudes.
    function automatic logic [EXP_WIDTH-1:0] model_exp(input blk_t b);
        int acc;
        int e;
        int v;
        acc = 0;
        e   = 0;
        for (int k = 0; k < NUM_BEATS; k++) begin
            for (int i = 0; i < IN_SIZE; i++) begin
                v   = int'($signed(b[k][i]));
                acc = acc | ((v < 0) ? -v : v);
            end
        end
        while ((acc >> e) != 0) e++;
        return EXP_WIDTH'(e);
    endfunction

    function automatic beat_t mk(input int a, input int b, input int c, input int d);
        beat_t r;
        r[0] = 16'(a);
        r[1] = 16'(b);
        r[2] = 16'(c);
        r[3] = 16'(d);
        return r;
    endfunction

    function automatic blk_t rand_blk();
        blk_t  r;
        logic [31:0] x;
        for (int k = 0; k < NUM_BEATS; k++) begin
            for (int i = 0; i < IN_SIZE; i++) begin
                x       = $urandom;
                r[k][i] = x[15:0] >> $urandom_range(0, 15);
            end
        end
        return r;
    endfunction

    // Downstream ready: random under backpressure, otherwise always high.
    always begin
        @(posedge clk);
        #1;
        data_out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ------------------------------------------------------------------
    // Output monitor, sampled on the falling edge
    // ------------------------------------------------------------------
    logic                 prev_rst   = 1'b0;
    logic                 prev_stall = 1'b0;
    logic                 prev_last  = 1'b0;
    beat_t                h_data;
    logic [EXP_WIDTH-1:0] h_exp;
    logic                 h_last;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_in_ready", 64'(data_in_ready), 64'd0);
            check("rst_out_valid", 64'(data_out_valid), 64'd0);
        end else begin
            if (prev_rst) begin
                check("post_rst_in_ready", 64'(data_in_ready), 64'd1);
                check("post_rst_out_valid", 64'(data_out_valid), 64'd0);
                check("post_rst_exp", 64'(data_out_exp), 64'd0);
            end
            if (prev_last) begin
                check("in_ready_after_last", 64'(data_in_ready), 64'd1);
            end
            if (data_out_valid) begin
                check("in_ready_low_in_emit", 64'(data_in_ready), 64'd0);
            end
            if (prev_stall) begin
                check("stall_data", 64'(dout_p), 64'(h_data));
                check("stall_exp", 64'(data_out_exp), 64'(h_exp));
                check("stall_last", 64'(data_out_last), 64'(h_last));
            end
            if (data_out_valid && data_out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    it = sb.pop_front();
                    check("out_data", 64'(dout_p), 64'(it.data));
                    check("out_exp", 64'(data_out_exp), 64'(it.exp));
                    check("out_last", 64'(data_out_last), 64'(it.last));
                end
            end
        end
        prev_rst   = rst;
        prev_stall = !rst && data_out_valid && !data_out_ready;
        prev_last  = !rst && data_out_valid && data_out_ready && data_out_last;
        h_data     = dout_p;
        h_exp      = data_out_exp;
        h_last     = data_out_last;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic send_beat(input beat_t b, input bit gaps);
        int t;
        if (gaps && $urandom_range(0, 2) == 0) begin
            din_p         = beat_t'({$urandom, $urandom});
            data_in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        din_p         = b;
        data_in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!data_in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!data_in_ready) check("in_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
    endtask

    task automatic send_block(input blk_t b, input int nb, input bit gaps);
        logic [EXP_WIDTH-1:0] e;
        item_t x;
        for (int k = 0; k < nb; k++) send_beat(b[k], gaps);
        if (nb == NUM_BEATS) begin
            e = model_exp(b);
            for (int k = 0; k < NUM_BEATS; k++) begin
                x.data = b[k];
                x.exp  = e;
                x.last = (k == NUM_BEATS - 1);
                sb.push_back(x);
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    blk_t blk;

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic block: or_acc = 7 -> exp 3
        blk[0] = mk(4, 0, 0, 0);
        blk[1] = mk(1, 2, 0, 0);
        blk[2] = mk(0, 0, 0, 0);
        blk[3] = mk(3, 0, 0, 0);
        check("model_basic", 64'(model_exp(blk)), 64'd3);
        send_block(blk, NUM_BEATS, 1'b0);
        drain();

        // Most negative lane -> exp 16
        blk[0] = mk(0, 0, 0, 0);
        blk[1] = mk(0, 0, -32768, 0);
        blk[2] = mk(0, 0, 0, 0);
        blk[3] = mk(0, 0, 0, 0);
        send_block(blk, NUM_BEATS, 1'b0);
        drain();

        // Single -1 lane -> exp 1
        blk[1] = mk(0, 0, 0, 0);
        blk[3] = mk(0, -1, 0, 0);
        send_block(blk, NUM_BEATS, 1'b0);
        drain();

        // All zero -> exp 0
        blk[3] = mk(0, 0, 0, 0);
        send_block(blk, NUM_BEATS, 1'b0);
        drain();

        // Backpressure with idle input gaps
        bp_mode = 1'b1;
        for (int n = 0; n < 3; n++) send_block(rand_blk(), NUM_BEATS, 1'b1);
        drain();
        bp_mode = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back blocks, decreasing magnitude so a stale or_acc shows
        blk[0] = mk(16'h4000, 0, 0, 0);
        blk[1] = mk(0, 0, 0, 0);
        blk[2] = mk(0, 0, 0, 0);
        blk[3] = mk(0, 0, 0, 0);
        send_block(blk, NUM_BEATS, 1'b0);
        blk[0] = mk(0, 0, 0, 9);
        send_block(blk, NUM_BEATS, 1'b0);
        send_block(rand_blk(), NUM_BEATS, 1'b0);
        drain();

        // Reset after two accepted beats of a large-magnitude block
        blk[0] = mk(16'h7fff, 0, 0, 0);
        blk[1] = mk(0, 16'h8000, 0, 0);
        send_block(blk, 2, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        blk[0] = mk(2, 0, 0, 0);
        blk[1] = mk(0, 1, 0, 0);
        blk[2] = mk(0, 0, 0, 0);
        blk[3] = mk(0, 0, -3, 0);
        send_block(blk, NUM_BEATS, 1'b0);
        drain();

        repeat (5) @(posedge clk);
        #1;
        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
